// File: rtl/imem_pkg.sv
// Shared constants and types for the 32x32 instruction memory and its loader.
// Holds the memory geometry, the byte-stream format and the loader state encoding.
package imem_pkg;

    localparam int IMEM_ADDR_W    = 5;
    localparam int IMEM_DEPTH     = 32;
    localparam int IMEM_DATA_W    = 32;

    localparam int HDR_MIN        = 1;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        BYTES = 2'd2,
        WRITE = 2'd3
    } ld_state_e;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream writer for the instruction memory: header byte N, then N big-endian words.
// Packs four bytes per word and issues one write strobe per word while holding busy.
//
// state | meaning
// IDLE  | waiting for start; done/error show the outcome of the last load
// HDR   | accepting the word-count header byte
// BYTES | shifting in the four bytes of the current word
// WRITE | single-cycle write strobe for the packed word
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DEPTH  = IMEM_DEPTH,
    parameter int DATA_W = IMEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    ld_state_e         state_q;
    ld_state_e         state_d;
    logic [CNT_W-1:0]  remaining;
    logic [ADDR_W-1:0] word_addr;
    logic [1:0]        byte_idx;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_next;
    logic              hs;
    logic              hdr_ok;
    logic              last_byte;

    // Both outputs decode registered state only, so in_valid never reaches in_ready.
    assign in_ready   = (state_q == HDR) || (state_q == BYTES);
    assign wr_en      = (state_q == WRITE);

    assign hs         = in_valid && in_ready;
    assign hdr_ok     = ({24'd0, in_data} >= 32'(HDR_MIN)) && ({24'd0, in_data} <= 32'(DEPTH));
    assign last_byte  = (byte_idx == 2'(BYTES_PER_WORD - 1));
    assign shift_next = {shift[DATA_W-9:0], in_data};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = HDR;
            HDR:     if (hs) state_d = hdr_ok ? BYTES : IDLE;
            BYTES:   if (hs && last_byte) state_d = WRITE;
            WRITE:   state_d = (remaining == CNT_W'(1)) ? IDLE : BYTES;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            remaining <= '0;
            word_addr <= '0;
            byte_idx  <= '0;
            shift     <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        error <= 1'b0;
                    end
                end
                HDR: begin
                    if (hs) begin
                        if (hdr_ok) begin
                            remaining <= in_data[CNT_W-1:0];
                            word_addr <= '0;
                            byte_idx  <= '0;
                        end else begin
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end
                    end
                end
                BYTES: begin
                    if (hs) begin
                        shift    <= shift_next;
                        byte_idx <= byte_idx + 2'd1;
                        // Latch the write port on the 4th byte so it holds between strobes.
                        if (last_byte) begin
                            wr_addr <= word_addr;
                            wr_data <= shift_next;
                        end
                    end
                end
                WRITE: begin
                    word_addr <= word_addr + ADDR_W'(1);
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        busy <= 1'b0;
                        done <= 1'b1;
                    end else begin
                        byte_idx <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: random and directed byte streams compared
// against a stream-level model of the expected memory writes.
module tb_imem_loader;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;

    int nvec = 0;
    int nerr = 0;
    int cyc  = 0;
    int rdy_viol = 0;

    logic [4:0]  got_addr[$];
    logic [31:0] got_data[$];
    int          got_cyc[$];
    logic [4:0]  exp_addr[$];
    logic [31:0] exp_data[$];
    int          hs_cyc[$];

    imem_loader dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!reset && wr_en) begin
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
            got_cyc.push_back(cyc);
            if (in_ready) rdy_viol++;
        end
    end

    function automatic bq_t mk_stream(input int n, input wq_t w);
        bq_t b;
        b.push_back(8'(n));
        foreach (w[k]) begin
            b.push_back(w[k][31:24]);
            b.push_back(w[k][23:16]);
            b.push_back(w[k][15:8]);
            b.push_back(w[k][7:0]);
        end
        return b;
    endfunction

    // Reference: a valid header N yields N writes at addresses 0..N-1, words MSB-first.
    task automatic build_expect(input bq_t b);
        int n;
        exp_addr.delete();
        exp_data.delete();
        n = int'(b[0]);
        if (n >= 1 && n <= 32) begin
            for (int k = 0; k < n; k++) begin
                exp_addr.push_back(5'(k));
                exp_data.push_back({b[1+4*k], b[2+4*k], b[3+4*k], b[4+4*k]});
            end
        end
    endtask

    task automatic clear_logs();
        got_addr.delete();
        got_data.delete();
        got_cyc.delete();
        hs_cyc.delete();
        rdy_viol = 0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
    endtask

    task automatic send_bytes(input bq_t b, input int gap_pct, input int start_at);
        bit pulsed = 0;
        for (int i = 0; i < b.size(); i++) begin
            int  waited = 0;
            bit  taken  = 0;
            while (!taken) begin
                @(negedge clk);
                start = (i == start_at && !pulsed);
                if (start) pulsed = 1;
                if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                end else begin
                    in_valid = 1'b1;
                    in_data  = b[i];
                    if (in_ready) begin
                        taken = 1;
                        if (i > 0 && (i % 4) == 0) hs_cyc.push_back(cyc + 1);
                    end
                end
                waited++;
                if (!taken && waited > 200) begin
                    nvec++; nerr++;
                    $display("FAIL byte_accept idx=%0d: in_ready stayed low, required a handshake within 200 cycles", i);
                    in_valid = 1'b0;
                    start    = 1'b0;
                    return;
                end
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        nvec++;
        if (busy !== 1'b0) begin
            nerr++;
            $display("FAIL %s_idle: busy=%b, required 0 within 100 cycles", tag, busy);
        end
    endtask

    task automatic run_load(input bq_t b, input int gap_pct, input int start_at, input string tag);
        clear_logs();
        build_expect(b);
        do_start();
        send_bytes(b, gap_pct, start_at);
        wait_idle(tag);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        nvec++;
        if ({in_ready, wr_en, wr_addr, wr_data, busy, done, error} !== '0) begin
            nerr++;
            $display("FAIL reset_outputs: rdy=%b wr_en=%b addr=%h data=%h busy=%b done=%b err=%b, required all 0",
                     in_ready, wr_en, wr_addr, wr_data, busy, done, error);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        wq_t w = '{32'h24100000, 32'h24110004, 32'h24120008};
        run_load(mk_stream(3, w), 0, -1, "basic");
        nvec++;
        if (got_addr.size() != exp_addr.size()) begin
            nerr++;
            $display("FAIL basic_count: got %0d writes, required %0d", got_addr.size(), exp_addr.size());
        end
        for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
            nvec++;
            if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k]) begin
                nerr++;
                $display("FAIL basic_write[%0d]: addr=%h data=%h, required addr=%h data=%h",
                         k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
            end
            nvec++;
            if (k >= hs_cyc.size() || got_cyc[k] != hs_cyc[k]) begin
                nerr++;
                $display("FAIL basic_latency[%0d]: write cycle %0d, required one cycle after 4th byte", k, got_cyc[k]);
            end
        end
        nvec++;
        if (done !== 1'b1 || busy !== 1'b0 || error !== 1'b0) begin
            nerr++;
            $display("FAIL basic_status: done=%b busy=%b err=%b, required 1 0 0", done, busy, error);
        end
    endtask

    task automatic test_bad_header();
        logic [7:0] hdrs[3];
        hdrs[0] = 8'h00;
        hdrs[1] = 8'h21;
        hdrs[2] = 8'($urandom_range(34, 255));
        for (int h = 0; h < 3; h++) begin
            bq_t b;
            b.push_back(hdrs[h]);
            clear_logs();
            do_start();
            @(negedge clk);
            start = 1'b0;
            nvec++;
            if (error !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                nerr++;
                $display("FAIL bad_start_clear[%0d]: err=%b busy=%b done=%b, required 0 1 0", h, error, busy, done);
            end
            send_bytes(b, 0, -1);
            wait_idle("bad_hdr");
            repeat (4) @(negedge clk);
            nvec++;
            if (error !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || got_addr.size() != 0) begin
                nerr++;
                $display("FAIL bad_hdr[%h]: err=%b busy=%b done=%b writes=%0d, required 1 0 0 0",
                         hdrs[h], error, busy, done, got_addr.size());
            end
        end
    endtask

    task automatic test_full();
        wq_t w;
        for (int k = 0; k < 32; k++) w.push_back(32'(k));
        run_load(mk_stream(32, w), 0, -1, "full");
        nvec++;
        if (got_addr.size() != 32) begin
            nerr++;
            $display("FAIL full_count: got %0d writes, required 32", got_addr.size());
        end
        for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
            nvec++;
            if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k]) begin
                nerr++;
                $display("FAIL full_write[%0d]: addr=%h data=%h, required addr=%h data=%h",
                         k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
            end
        end
        nvec++;
        if (done !== 1'b1 || wr_addr !== 5'd31 || wr_data !== 32'h0000001F) begin
            nerr++;
            $display("FAIL full_last: done=%b addr=%h data=%h, required 1 1f 0000001f", done, wr_addr, wr_data);
        end
    endtask

    task automatic test_gaps();
        for (int r = 0; r < 4; r++) begin
            wq_t w;
            int  n;
            if (r == 0) begin
                n = 3;
                w = '{32'h24100000, 32'h24110004, 32'h24120008};
            end else begin
                n = $urandom_range(1, 8);
                for (int k = 0; k < n; k++) w.push_back($urandom);
            end
            run_load(mk_stream(n, w), 50, -1, "gaps");
            nvec++;
            if (got_addr.size() != exp_addr.size() || rdy_viol != 0) begin
                nerr++;
                $display("FAIL gaps_count[%0d]: got %0d writes (in_ready high in WRITE %0d times), required %0d and 0",
                         r, got_addr.size(), rdy_viol, exp_addr.size());
            end
            for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
                nvec++;
                if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k] ||
                    k >= hs_cyc.size() || got_cyc[k] != hs_cyc[k]) begin
                    nerr++;
                    $display("FAIL gaps_write[%0d.%0d]: addr=%h data=%h cyc=%0d, required addr=%h data=%h one cycle after 4th byte",
                             r, k, got_addr[k], got_data[k], got_cyc[k], exp_addr[k], exp_data[k]);
                end
            end
            nvec++;
            if (done !== 1'b1) begin
                nerr++;
                $display("FAIL gaps_done[%0d]: done=%b, required 1", r, done);
            end
        end
    endtask

    task automatic test_reset_mid();
        wq_t w = '{32'hA1B2C3D4, 32'h55667788, 32'h99AABBCC};
        bq_t full = mk_stream(3, w);
        bq_t part;
        for (int i = 0; i < 7; i++) part.push_back(full[i]);
        clear_logs();
        do_start();
        send_bytes(part, 0, -1);
        reset = 1'b1;
        #1;
        nvec++;
        if ({in_ready, wr_en, wr_addr, wr_data, busy, done, error} !== '0) begin
            nerr++;
            $display("FAIL reset_mid: rdy=%b wr_en=%b addr=%h data=%h busy=%b done=%b err=%b, required all 0",
                     in_ready, wr_en, wr_addr, wr_data, busy, done, error);
        end
        nvec++;
        if (got_addr.size() != 1 || got_data[0] !== 32'hA1B2C3D4) begin
            nerr++;
            $display("FAIL reset_mid_prior: %0d writes before reset, required 1 of a1b2c3d4", got_addr.size());
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_load(mk_stream(1, '{32'h0800000C}), 0, -1, "after_reset");
        nvec++;
        if (got_addr.size() != 1 || got_addr[0] !== 5'd0 || got_data[0] !== 32'h0800000C || done !== 1'b1) begin
            nerr++;
            $display("FAIL after_reset_load: writes=%0d addr=%h data=%h done=%b, required 1 write 00/0800000c done 1",
                     got_addr.size(), wr_addr, wr_data, done);
        end
    endtask

    task automatic test_start_ignored();
        wq_t w = '{32'hDEADBEEF, 32'h01234567};
        run_load(mk_stream(2, w), 0, 3, "start_ign");
        nvec++;
        if (got_addr.size() != exp_addr.size() || done !== 1'b1 || error !== 1'b0) begin
            nerr++;
            $display("FAIL start_ign_status: writes=%0d done=%b err=%b, required %0d 1 0",
                     got_addr.size(), done, error, exp_addr.size());
        end
        for (int k = 0; k < exp_addr.size() && k < got_addr.size(); k++) begin
            nvec++;
            if (got_addr[k] !== exp_addr[k] || got_data[k] !== exp_data[k]) begin
                nerr++;
                $display("FAIL start_ign_write[%0d]: addr=%h data=%h, required addr=%h data=%h",
                         k, got_addr[k], got_data[k], exp_addr[k], exp_data[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_header();
        test_full();
        test_gaps();
        test_reset_mid();
        test_start_ignored();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
